// File: rtl/bip_datapath_if.sv
// BIP datapath bus: control word and operand from the decoder,
// accumulator/status back, plus a debug read port into the data RAM.
interface bip_datapath_if #(
   parameter int DATA_W    = 16,
   parameter int OPERAND_W = 11,
   parameter int ADDR_W    = 6
);
   logic                 en;
   logic [OPERAND_W-1:0] operand;
   logic [1:0]           sel_a;
   logic                 sel_b;
   logic                 wr_acc;
   logic                 op;
   logic                 wr_ram;
   logic                 rd_ram;
   logic                 ready;
   logic [DATA_W-1:0]    acc;
   logic                 ovf;
   logic [ADDR_W-1:0]    dbg_addr;
   logic [DATA_W-1:0]    dbg_data;

   modport master (
      output en, operand, sel_a, sel_b, wr_acc, op,
      output wr_ram, rd_ram, dbg_addr,
      input  ready, acc, ovf, dbg_data
   );

   modport slave (
      input  en, operand, sel_a, sel_b, wr_acc, op,
      input  wr_ram, rd_ram, dbg_addr,
      output ready, acc, ovf, dbg_data
   );
endinterface

// File: rtl/bip_datapath.sv
// BIP accumulator datapath: ACC, add/sub ALU, data RAM with a
// zero-fill sweep after reset before instructions are accepted.
module bip_datapath #(
   parameter int DATA_W    = 16,
   parameter int OPERAND_W = 11,
   parameter int ADDR_W    = 6
) (
   input  logic          i_clk,
   input  logic          i_reset,
   bip_datapath_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      S_INIT,
      S_RUN
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   cnt;
   logic                ready;
   logic                ovf;
   logic [DATA_W-1:0]   acc;
   logic [DATA_W-1:0]   ram [DEPTH];

   logic                ex;
   logic [ADDR_W-1:0]   addr;
   logic [DATA_W-1:0]   imm;
   logic [DATA_W-1:0]   rd;
   logic [DATA_W-1:0]   b;
   logic [DATA_W-1:0]   alu;
   logic [DATA_W-1:0]   acc_nx;
   logic                ovf_hit;

   assign ex   = bus.en & ready;
   assign addr = bus.operand[ADDR_W-1:0];
   assign imm  = {{(DATA_W-OPERAND_W){bus.operand[OPERAND_W-1]}},
                  bus.operand};
   assign rd   = bus.rd_ram ? ram[addr] : '0;
   assign b    = bus.sel_b ? imm : rd;
   assign alu  = bus.op ? acc - b : acc + b;

   // Signed overflow from operand and result sign bits.
   always_comb begin
      logic sa, sb, sr;
      sa = acc[DATA_W-1];
      sb = b[DATA_W-1];
      sr = alu[DATA_W-1];
      ovf_hit = 1'b0;
      if (bus.op)
         ovf_hit = (sa != sb) && (sr != sa);
      else
         ovf_hit = (sa == sb) && (sr != sa);
   end

   // Accumulator source select.
   always_comb begin
      acc_nx = acc;
      unique case (bus.sel_a)
         2'b00: acc_nx = rd;
         2'b01: acc_nx = imm;
         2'b10: acc_nx = alu;
         2'b11: acc_nx = acc;
      endcase
   end

   // Init sequencer: sweep every RAM word once, then run forever.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= S_INIT;
         cnt   <= '0;
         ready <= 1'b0;
      end else begin
         unique case (state)
            S_INIT: begin
               cnt <= cnt + 1'b1;
               if (&cnt) begin
                  state <= S_RUN;
                  ready <= 1'b1;
               end
            end
            S_RUN: ready <= 1'b1;
         endcase
      end
   end

   // RAM write port: zero-fill during init, ACC store when running.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         if (state == S_INIT)
            ram[cnt] <= '0;
         else if (ex && bus.wr_ram)
            ram[addr] <= acc;
      end
   end

   // Accumulator and sticky overflow flag.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         acc <= '0;
         ovf <= 1'b0;
      end else if (ex && bus.wr_acc) begin
         acc <= acc_nx;
         if (bus.sel_a == 2'b10 && ovf_hit)
            ovf <= 1'b1;
      end
   end

   assign bus.ready    = ready;
   assign bus.acc      = acc;
   assign bus.ovf      = ovf;
   assign bus.dbg_data = ram[bus.dbg_addr];
endmodule

// File: tb/tb_bip_datapath.sv
// Bench for bip_datapath: directed BIP programs plus random
// instruction streams checked each cycle against a behavioural model.
module tb_bip_datapath;
   localparam int DW    = 16;
   localparam int OW    = 11;
   localparam int AW    = 6;
   localparam int DEPTH = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bip_datapath_if #(.DATA_W(DW), .OPERAND_W(OW), .ADDR_W(AW)) bus ();

   bip_datapath #(.DATA_W(DW), .OPERAND_W(OW), .ADDR_W(AW)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   logic [DW-1:0] m_mem [DEPTH];
   bit            m_known [DEPTH];
   logic [DW-1:0] m_acc = '0;
   bit            m_ovf = 1'b0;
   int            init_cnt = 0;
   bit            chk_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Model of one clock edge, using the inputs present before the edge.
   task automatic model_edge();
      logic [AW-1:0] a;
      logic [DW-1:0] imm, rdv, bv, nacc;
      int sa, sb, full;
      bit ov;
      if (rst) begin
         m_acc    = '0;
         m_ovf    = 1'b0;
         init_cnt = 0;
      end else if (init_cnt < DEPTH) begin
         m_mem[init_cnt]   = '0;
         m_known[init_cnt] = 1'b1;
         init_cnt++;
      end else if (bus.en) begin
         a    = bus.operand[AW-1:0];
         imm  = DW'($signed(bus.operand));
         rdv  = bus.rd_ram ? m_mem[a] : '0;
         bv   = bus.sel_b ? imm : rdv;
         sa   = $signed(m_acc);
         sb   = $signed(bv);
         full = bus.op ? sa - sb : sa + sb;
         ov   = (full > 32767) || (full < -32768);
         case (bus.sel_a)
            2'b00:   nacc = rdv;
            2'b01:   nacc = imm;
            2'b10:   nacc = full[DW-1:0];
            default: nacc = m_acc;
         endcase
         if (bus.wr_ram) begin
            m_mem[a]   = m_acc;
            m_known[a] = 1'b1;
         end
         if (bus.wr_acc) begin
            if (bus.sel_a == 2'b10 && ov)
               m_ovf = 1'b1;
            m_acc = nacc;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic rand_ctl();
      bus.en       = 1'($urandom);
      bus.operand  = OW'($urandom);
      bus.sel_a    = 2'($urandom);
      bus.sel_b    = 1'($urandom);
      bus.wr_acc   = 1'($urandom);
      bus.op       = 1'($urandom);
      bus.wr_ram   = 1'($urandom);
      bus.rd_ram   = 1'($urandom);
      bus.dbg_addr = AW'($urandom);
   endtask

   task automatic ins(input logic [1:0] sa, input logic sb,
                      input logic wa, input logic o,
                      input logic wr, input logic rr,
                      input logic [OW-1:0] opnd);
      bus.en      = 1'b1;
      bus.sel_a   = sa;
      bus.sel_b   = sb;
      bus.wr_acc  = wa;
      bus.op      = o;
      bus.wr_ram  = wr;
      bus.rd_ram  = rr;
      bus.operand = opnd;
      step();
   endtask

   task automatic ldi(input logic [OW-1:0] v);
      ins(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, v);
   endtask
   task automatic sto(input logic [OW-1:0] a);
      ins(2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, a);
   endtask
   task automatic add(input logic [OW-1:0] a);
      ins(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, a);
   endtask
   task automatic addi(input logic [OW-1:0] v);
      ins(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, v);
   endtask
   task automatic subi(input logic [OW-1:0] v);
      ins(2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, v);
   endtask
   task automatic ld(input logic [OW-1:0] a);
      ins(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, a);
   endtask

   task automatic peek(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                       input string name);
      bus.dbg_addr = a;
      #1;
      chk(name, bus.dbg_data, exp);
   endtask

   // Reset with random controls, then count the init sweep length.
   task automatic reset_init();
      int n;
      rst = 1'b1;
      rand_ctl();
      step();
      rst = 1'b0;
      chk_on = 1'b1;
      chk("rst_acc", bus.acc, 0);
      chk("rst_ovf", bus.ovf, 0);
      chk("rst_ready", bus.ready, 0);
      n = 0;
      while (bus.ready !== 1'b1 && n < 200) begin
         rand_ctl();
         step();
         n++;
      end
      chk("init_len", n, 64);
      chk("init_acc", bus.acc, 0);
   endtask

   // Per-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("acc", bus.acc, m_acc);
         chk("ovf", bus.ovf, m_ovf);
         chk("ready", bus.ready, init_cnt == DEPTH);
         if (m_known[bus.dbg_addr])
            chk("dbg", bus.dbg_data, m_mem[bus.dbg_addr]);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      rand_ctl();
      for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

      reset_init();
      bus.en = 1'b0;
      for (int a = 0; a < DEPTH; a++)
         peek(AW'(a), 16'h0000, "zero_fill");

      ldi(11'd5);
      chk("ldi5", bus.acc, 16'd5);
      sto(11'd3);
      peek(6'd3, 16'd5, "sto3");

      add(11'd3);
      chk("add3", bus.acc, 16'd10);
      subi(11'h7FE);
      chk("subi_m2", bus.acc, 16'd12);
      ld(11'd3);
      chk("ld3", bus.acc, 16'd5);

      ldi(11'd1023);
      repeat (5) begin
         sto(11'd10);
         add(11'd10);
      end
      chk("dbl", bus.acc, 16'h7FE0);
      addi(11'd31);
      chk("max_pos", bus.acc, 16'h7FFF);
      sto(11'd20);
      chk("no_ovf_yet", bus.ovf, 0);
      ldi(11'd1023);
      add(11'd20);
      chk("wrap", bus.acc, 16'h83FE);
      chk("ovf_set", bus.ovf, 1);
      ldi(11'd0);
      chk("ovf_sticky", bus.ovf, 1);
      chk("ldi0", bus.acc, 0);

      ldi(11'd9);
      sto(11'h043);
      peek(6'd3, 16'd9, "alias43");
      ldi(11'd4);
      ins(2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 11'h003);
      chk("rbw_acc", bus.acc, 16'd9);
      peek(6'd3, 16'd4, "rbw_ram");

      ldi(11'd7);
      chk("ldi7", bus.acc, 16'd7);
      reset_init();

      for (int i = 0; i < 3000; i++) begin
         rand_ctl();
         rst = ($urandom_range(0, 999) == 0);
         step();
         rst = 1'b0;
      end

      chk_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
